cam: RTL and testbench

//   16-entry content-addressable memory. Each entry holds a 16-bit key and a
//   16-bit associated data word. A write stores or updates a key/data pair. A

---
 rtl/cam_pkg.sv | 17 +
 rtl/cam_prio_enc.sv | 23 ++
 rtl/cam.sv | 72 +++++++
 tb/tb_cam.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared constants and the entry record for the 16-entry key/data CAM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cam_pkg;

    localparam int KEY_W  = 16;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef struct packed {
        logic              valid;
        logic [KEY_W-1:0]  key;
        logic [DATA_W-1:0] data;
    } cam_entry_t;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder over the CAM match vector.
// Latency: combinational.
// Backpressure: none; pure function of the match vector.
module cam_prio_enc
    import cam_pkg::*;
(
    input  logic [DEPTH-1:0]  match,
    output logic              any,
    output logic [ADDR_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last to win
    always_comb begin
        any = |match;
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx = ADDR_W'(i);
            end
        end
    end

endmodule

// File: rtl/cam.sv
// 16-entry CAM: write stores/updates a key/data pair, lookup returns hit/addr/data.
// Latency: results registered, visible one clock after the operation is sampled.
// Backpressure: none; accepts one operation per enabled cycle.
module cam
    import cam_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cam_enable,
    input  logic              wr,
    input  logic [KEY_W-1:0]  cam_data_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              cam_hit_out,
    output logic [ADDR_W-1:0] cam_addr_out,
    output logic [DATA_W-1:0] data_out
);

    cam_entry_t        entries [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [DEPTH-1:0]  match;
    logic              match_any;
    logic [ADDR_W-1:0] match_idx;

    // Parallel compare; an invalid entry never matches regardless of stale key bits
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = entries[i].valid && (entries[i].key == cam_data_in);
        end
    end

    // One encoder serves both the write-update path and the lookup path
    cam_prio_enc u_prio_enc (
        .match (match),
        .any   (match_any),
        .idx   (match_idx)
    );

    // Entry storage, FIFO allocation pointer and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
            wr_ptr       <= '0;
            cam_hit_out  <= 1'b0;
            cam_addr_out <= '0;
            data_out     <= '0;
        end else if (cam_enable) begin
            if (wr) begin
                cam_hit_out <= 1'b0;
                if (match_any) begin
                    // Existing key: refresh data in place, no new slot consumed
                    entries[match_idx].data <= data_in;
                    cam_addr_out            <= match_idx;
                end else begin
                    // New key: allocate oldest slot, overwriting when full
                    entries[wr_ptr] <= '{valid: 1'b1, key: cam_data_in, data: data_in};
                    cam_addr_out    <= wr_ptr;
                    wr_ptr          <= (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                end
            end else begin
                cam_hit_out  <= match_any;
                cam_addr_out <= match_any ? match_idx : '0;
                data_out     <= match_any ? entries[match_idx].data : '0;
            end
        end else begin
            cam_hit_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cam.sv
// Directed bench for the CAM: vector table plus hand-written fill/replace/reset sequences.
// Latency: outputs sampled 1 ns after the edge that registers them.
// Backpressure: n/a.
module tb_cam;
    import cam_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cam_enable;
    logic              wr;
    logic [KEY_W-1:0]  cam_data_in;
    logic [DATA_W-1:0] data_in;
    logic              cam_hit_out;
    logic [ADDR_W-1:0] cam_addr_out;
    logic [DATA_W-1:0] data_out;

    int checks   = 0;
    int failures = 0;

    cam dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cam_enable   (cam_enable),
        .wr           (wr),
        .cam_data_in  (cam_data_in),
        .data_in      (data_in),
        .cam_hit_out  (cam_hit_out),
        .cam_addr_out (cam_addr_out),
        .data_out     (data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic              en;
        logic              w;
        logic [KEY_W-1:0]  key;
        logic [DATA_W-1:0] dat;
        int                reps;
        logic              exp_hit;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_dat;
    } vec_t;

    vec_t vecs [14];

    task automatic step(input logic en, input logic w,
                        input logic [KEY_W-1:0] k, input logic [DATA_W-1:0] d);
        cam_enable  = en;
        wr          = w;
        cam_data_in = k;
        data_in     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic hit,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] dat);
        checks++;
        if (cam_hit_out !== hit || cam_addr_out !== addr || data_out !== dat) begin
            failures++;
            $display("FAIL %s: got hit=%0b addr=%0d data=%h, expected hit=%0b addr=%0d data=%h",
                     name, cam_hit_out, cam_addr_out, data_out, hit, addr, dat);
        end
    endtask

    initial begin
        vecs[0]  = '{"lookup_after_reset", 1'b1, 1'b0,  16'h0251, 16'h0000, 1,  1'b0, 4'd0, 16'h0000};
        vecs[1]  = '{"write_0251_x10",     1'b1, 1'b1,  16'h0251, 16'h00AF, 10, 1'b0, 4'd0, 16'h0000};
        vecs[2]  = '{"lookup_0251",        1'b1, 1'b0,  16'h0251, 16'h0000, 1,  1'b1, 4'd0, 16'h00AF};
        vecs[3]  = '{"write_0252_x10",     1'b1, 1'b1,  16'h0252, 16'h000F, 10, 1'b0, 4'd1, 16'h00AF};
        vecs[4]  = '{"write_0069_x10",     1'b1, 1'b1,  16'h0069, 16'h0012, 10, 1'b0, 4'd2, 16'h00AF};
        vecs[5]  = '{"lookup_0252",        1'b1, 1'b0,  16'h0252, 16'h0000, 1,  1'b1, 4'd1, 16'h000F};
        vecs[6]  = '{"lookup_0069",        1'b1, 1'b0,  16'h0069, 16'h0000, 1,  1'b1, 4'd2, 16'h0012};
        vecs[7]  = '{"lookup_0251_again",  1'b1, 1'b0,  16'h0251, 16'h0000, 1,  1'b1, 4'd0, 16'h00AF};
        vecs[8]  = '{"rewrite_0252",       1'b1, 1'b1,  16'h0252, 16'h1234, 1,  1'b0, 4'd1, 16'h00AF};
        vecs[9]  = '{"lookup_0252_new",    1'b1, 1'b0,  16'h0252, 16'h0000, 1,  1'b1, 4'd1, 16'h1234};
        vecs[10] = '{"write_0300_slot3",   1'b1, 1'b1,  16'h0300, 16'h0003, 1,  1'b0, 4'd3, 16'h1234};
        vecs[11] = '{"lookup_0300",        1'b1, 1'b0,  16'h0300, 16'h0000, 1,  1'b1, 4'd3, 16'h0003};
        vecs[12] = '{"disabled_wr_x",      1'b0, 1'bx,  16'h0400, 16'h0044, 3,  1'b0, 4'd3, 16'h0003};
        vecs[13] = '{"lookup_0400_absent", 1'b1, 1'b0,  16'h0400, 16'h0000, 1,  1'b0, 4'd0, 16'h0000};

        rst_n = 1'b0;
        step(1'b0, 1'b0, 16'h0, 16'h0);
        step(1'b0, 1'b0, 16'h0, 16'h0);
        check("reset_state", 1'b0, 4'd0, 16'h0000);
        rst_n = 1'b1;

        for (int v = 0; v < 14; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) begin
                step(vecs[v].en, vecs[v].w, vecs[v].key, vecs[v].dat);
            end
            check(vecs[v].name, vecs[v].exp_hit, vecs[v].exp_addr, vecs[v].exp_dat);
        end

        // Fill slots 4..15; data_out holds 0 from the last miss
        for (int i = 4; i < DEPTH; i++) begin
            step(1'b1, 1'b1, 16'h1000 + 16'(i), 16'h2000 + 16'(i));
            check($sformatf("fill_slot%0d", i), 1'b0, 4'(i), 16'h0000);
        end
        step(1'b1, 1'b0, 16'h100F, 16'h0);
        check("lookup_slot15", 1'b1, 4'd15, 16'h200F);

        // Table full: the 17th key replaces slot 0
        step(1'b1, 1'b1, 16'hBEEF, 16'hBEE0);
        check("write_beef_wraps", 1'b0, 4'd0, 16'h200F);
        step(1'b1, 1'b0, 16'hBEEF, 16'h0);
        check("lookup_beef", 1'b1, 4'd0, 16'hBEE0);
        step(1'b1, 1'b0, 16'h0251, 16'h0);
        check("evicted_0251_miss", 1'b0, 4'd0, 16'h0000);
        step(1'b1, 1'b0, 16'h0252, 16'h0);
        check("0252_survives", 1'b1, 4'd1, 16'h1234);

        // In-place update while full must not advance the pointer
        step(1'b1, 1'b1, 16'h1004, 16'h4444);
        check("update_slot4", 1'b0, 4'd4, 16'h1234);
        step(1'b1, 1'b1, 16'hCAFE, 16'hCAF0);
        check("next_new_slot1", 1'b0, 4'd1, 16'h1234);
        step(1'b1, 1'b0, 16'h0252, 16'h0);
        check("evicted_0252_miss", 1'b0, 4'd0, 16'h0000);
        step(1'b1, 1'b0, 16'h1004, 16'h0);
        check("lookup_slot4_upd", 1'b1, 4'd4, 16'h4444);

        // Reset wins over a simultaneous write
        rst_n = 1'b0;
        step(1'b1, 1'b1, 16'hDEAD, 16'hD0D0);
        check("midrun_reset", 1'b0, 4'd0, 16'h0000);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 16'hBEEF, 16'h0);
        check("post_reset_beef_miss", 1'b0, 4'd0, 16'h0000);
        step(1'b1, 1'b0, 16'hCAFE, 16'h0);
        check("post_reset_cafe_miss", 1'b0, 4'd0, 16'h0000);
        step(1'b1, 1'b0, 16'hDEAD, 16'h0);
        check("post_reset_dead_miss", 1'b0, 4'd0, 16'h0000);
        step(1'b1, 1'b0, 16'h1004, 16'h0);
        check("post_reset_stale_miss", 1'b0, 4'd0, 16'h0000);
        step(1'b1, 1'b1, 16'h5555, 16'h0055);
        step(1'b1, 1'b1, 16'h6666, 16'h0066);
        check("post_reset_ptr_slot1", 1'b0, 4'd1, 16'h0000);
        step(1'b1, 1'b0, 16'h5555, 16'h0);
        check("post_reset_5555_slot0", 1'b1, 4'd0, 16'h0055);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
